// File: rtl/alu_opcol_pkg.sv
// Shared types, constants and two-operand decode for the ALU operand collector.
// Operand/command widths come from the global OP_WIDTH / CMD_WIDTH macros.
`ifndef OP_WIDTH
`define OP_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

package alu_opcol_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } opcol_state_t;

    localparam int OPCOL_TIMEOUT_DEFAULT = 16;

    // True when the command needs both OPA and OPB.
    function automatic logic is_two_op(input logic mode, input logic [`CMD_WIDTH-1:0] cmd);
        int unsigned code;
        logic        two_op;
        code   = 32'(cmd);
        two_op = 1'b0;
        if (mode) begin
            case (code)
                32'd0, 32'd1, 32'd2, 32'd3, 32'd8, 32'd9, 32'd10: two_op = 1'b1;
                default:                                           two_op = 1'b0;
            endcase
        end else begin
            case (code)
                32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd12, 32'd13: two_op = 1'b1;
                default:                                                   two_op = 1'b0;
            endcase
        end
        return two_op;
    endfunction

endpackage

// File: rtl/alu_opcol_timer.sv
// Wait-window counter for the operand collector; expire marks the last cycle of the window.
module alu_opcol_timer #(
    parameter int TIMEOUT_CYCLES = alu_opcol_pkg::OPCOL_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Cleared on window entry, advances per enabled cycle, parks on the last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end
    end

    assign expire = (count_r == LAST);

endmodule

// File: rtl/alu_operand_collector.sv
// Merges split OPA/OPB arrivals into one ALU transaction, with a timeout fallback.
// Optional `ALU_OPCOL_STATS_EN adds a saturating timeout_count output.
module alu_operand_collector
    import alu_opcol_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = OPCOL_TIMEOUT_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic [1:0]            in_valid,
    input  logic [`OP_WIDTH-1:0]  in_opa,
    input  logic [`OP_WIDTH-1:0]  in_opb,
    input  logic [`CMD_WIDTH-1:0] in_cmd,
    input  logic                  in_mode,
    input  logic                  in_cin,
    output logic [1:0]            INP_VALID,
    output logic [`OP_WIDTH-1:0]  OPA,
    output logic [`OP_WIDTH-1:0]  OPB,
    output logic [`CMD_WIDTH-1:0] CMD,
    output logic                  MODE,
    output logic                  CIN,
    output logic                  timeout,
    output logic                  busy
`ifdef ALU_OPCOL_STATS_EN
    ,
    output logic [7:0]            timeout_count
`endif
);

    opcol_state_t          state_r, state_s;
    logic                  held_b_r, held_b_s;
    logic [`OP_WIDTH-1:0]  held_op_r, held_op_s;
    logic [`CMD_WIDTH-1:0] held_cmd_r, held_cmd_s;
    logic                  held_mode_r, held_mode_s;
    logic                  held_cin_r, held_cin_s;

    logic [1:0]            iv_r, iv_s;
    logic [`OP_WIDTH-1:0]  opa_r, opa_s, opb_r, opb_s;
    logic [`CMD_WIDTH-1:0] cmd_r, cmd_s;
    logic                  mode_r, mode_s, cin_r, cin_s;
    logic                  timeout_r, timeout_s, busy_r;

    logic                  partner_s, expire_s, timer_clr_s, timer_en_s;

    alu_opcol_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (CE & timer_clr_s),
        .en     (CE & timer_en_s),
        .expire (expire_s)
    );

    // Next-state and next-output decode; data outputs hold unless a transaction issues.
    always_comb begin
        state_s     = state_r;
        held_b_s    = held_b_r;
        held_op_s   = held_op_r;
        held_cmd_s  = held_cmd_r;
        held_mode_s = held_mode_r;
        held_cin_s  = held_cin_r;
        iv_s        = 2'b00;
        opa_s       = opa_r;
        opb_s       = opb_r;
        cmd_s       = cmd_r;
        mode_s      = mode_r;
        cin_s       = cin_r;
        timeout_s   = 1'b0;
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b0;
        partner_s   = held_b_r ? in_valid[0] : in_valid[1];
        case (state_r)
            IDLE: begin
                if (in_valid == 2'b00) begin
                    iv_s = 2'b00;
                end else if ((in_valid == 2'b11) || !is_two_op(in_mode, in_cmd)) begin
                    iv_s   = in_valid;
                    opa_s  = in_opa;
                    opb_s  = in_opb;
                    cmd_s  = in_cmd;
                    mode_s = in_mode;
                    cin_s  = in_cin;
                end else begin
                    held_b_s    = in_valid[1];
                    held_op_s   = in_valid[1] ? in_opb : in_opa;
                    held_cmd_s  = in_cmd;
                    held_mode_s = in_mode;
                    held_cin_s  = in_cin;
                    timer_clr_s = 1'b1;
                    state_s     = WAIT;
                end
            end
            WAIT: begin
                if (partner_s) begin
                    iv_s    = 2'b11;
                    opa_s   = held_b_r ? in_opa : held_op_r;
                    opb_s   = held_b_r ? held_op_r : in_opb;
                    cmd_s   = held_cmd_r;
                    mode_s  = held_mode_r;
                    cin_s   = held_cin_r;
                    state_s = IDLE;
                end else if (expire_s) begin
                    iv_s = held_b_r ? 2'b10 : 2'b01;
                    if (held_b_r) begin
                        opb_s = held_op_r;
                    end else begin
                        opa_s = held_op_r;
                    end
                    cmd_s     = held_cmd_r;
                    mode_s    = held_mode_r;
                    cin_s     = held_cin_r;
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, held operand and output registers; RST wins over CE, CE low freezes all.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            held_b_r    <= 1'b0;
            held_op_r   <= '0;
            held_cmd_r  <= '0;
            held_mode_r <= 1'b0;
            held_cin_r  <= 1'b0;
            iv_r        <= 2'b00;
            opa_r       <= '0;
            opb_r       <= '0;
            cmd_r       <= '0;
            mode_r      <= 1'b0;
            cin_r       <= 1'b0;
            timeout_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else if (CE) begin
            state_r     <= state_s;
            held_b_r    <= held_b_s;
            held_op_r   <= held_op_s;
            held_cmd_r  <= held_cmd_s;
            held_mode_r <= held_mode_s;
            held_cin_r  <= held_cin_s;
            iv_r        <= iv_s;
            opa_r       <= opa_s;
            opb_r       <= opb_s;
            cmd_r       <= cmd_s;
            mode_r      <= mode_s;
            cin_r       <= cin_s;
            timeout_r   <= timeout_s;
            busy_r      <= (state_s == WAIT);
        end
    end

    assign INP_VALID = iv_r;
    assign OPA       = opa_r;
    assign OPB       = opb_r;
    assign CMD       = cmd_r;
    assign MODE      = mode_r;
    assign CIN       = cin_r;
    assign timeout   = timeout_r;
    assign busy      = busy_r;

`ifdef ALU_OPCOL_STATS_EN
    logic [7:0] timeout_count_r;

    // Saturating count of issued timeouts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            timeout_count_r <= 8'd0;
        end else if (CE && timeout_s && (timeout_count_r != 8'hFF)) begin
            timeout_count_r <= timeout_count_r + 8'd1;
        end
    end

    assign timeout_count = timeout_count_r;
`endif

endmodule
